player_ctrl: RTL and testbench

//  Player-ship controller, parametrised successor of the fixed-step mover. One position update per clk22 tick

---
 rtl/player_ctrl.sv | 168 ++++++++++++++++
 tb/tb_player_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
`timescale 1ns/1ps
// player_ctrl: keypad-driven player ship with clamped movement, lives and post-hit invulnerability.
// Build macro PLAYER_DIAG_NORM_EN scales each axis step to 3/4 when both axes move in one tick.
module player_ctrl #(
    parameter int W           = 10,
    parameter int X_MIN       = 10,
    parameter int X_MAX       = 430,
    parameter int Y_MIN       = 10,
    parameter int Y_MAX       = 465,
    parameter int X_INIT      = 220,
    parameter int Y_INIT      = 360,
    parameter int SPEED       = 7,
    parameter int FOCUS_SPEED = 3,
    parameter int LIVES       = 3,
    parameter int INVUL_TICKS = 64
) (
    input  logic         clk22,
    input  logic         rst_n,
    input  logic         gameover,
    input  logic         hit,
    input  logic         focus,
    input  logic [3:0]   btnstate,
    output logic [W-1:0] reimux,
    output logic [W-1:0] reimuy,
    output logic         invul,
    output logic [2:0]   lives,
    output logic         dead
);

    localparam int CW = $clog2(INVUL_TICKS + 1);

    localparam logic [W:0]    X_LO   = (W+1)'(X_MIN);
    localparam logic [W:0]    X_HI   = (W+1)'(X_MAX);
    localparam logic [W:0]    Y_LO   = (W+1)'(Y_MIN);
    localparam logic [W:0]    Y_HI   = (W+1)'(Y_MAX);
    localparam logic [W:0]    STEP_N = (W+1)'(SPEED);
    localparam logic [W:0]    STEP_F = (W+1)'(FOCUS_SPEED);
    localparam logic [W-1:0]  X_RST  = W'(X_INIT);
    localparam logic [W-1:0]  Y_RST  = W'(Y_INIT);
    localparam logic [2:0]    L_RST  = 3'(LIVES);
    localparam logic [CW-1:0] CNT_LD = CW'(INVUL_TICKS - 1);
`ifdef PLAYER_DIAG_NORM_EN
    localparam logic [W:0]    DIAG_N = (W+1)'((SPEED * 3) >> 2);
    localparam logic [W:0]    DIAG_F = (W+1)'((FOCUS_SPEED * 3) >> 2);
`endif

    typedef enum logic [1:0] {ALIVE = 2'd0, INVUL = 2'd1, DEAD = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic [2:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          invul_q, invul_d, dead_q, dead_d;
    logic [W:0]    step;
    logic [W-1:0]  x_mov, y_mov;
`ifdef PLAYER_DIAG_NORM_EN
    logic          x_mv, y_mv;
`endif

    // One axis: 10 = decrement, 01 = increment, in W+1 bits so nothing wraps; result always in [lo,hi].
    function automatic logic [W-1:0] move_axis(input logic [W-1:0] p, input logic [1:0] dir,
                                               input logic [W:0] step_v, input logic [W:0] lo,
                                               input logic [W:0] hi);
        logic [W:0] pe;
        logic [W:0] r;
        pe = {1'b0, p};
        r  = pe;
        if (dir == 2'b10) begin
            r = (pe >= lo + step_v) ? pe - step_v : lo;
        end else if (dir == 2'b01) begin
            r = (pe + step_v <= hi) ? pe + step_v : hi;
        end
        if (dir == 2'b10 || dir == 2'b01) begin
            if (r < lo) begin
                r = lo;
            end else if (r > hi) begin
                r = hi;
            end
        end
        return W'(r);
    endfunction

    always_comb begin
        step = focus ? STEP_F : STEP_N;
`ifdef PLAYER_DIAG_NORM_EN
        x_mv = btnstate[1] ^ btnstate[0];
        y_mv = btnstate[3] ^ btnstate[2];
        if (x_mv && y_mv) begin
            step = focus ? DIAG_F : DIAG_N;
        end
`endif
        x_mov = move_axis(x_q, btnstate[1:0], step, X_LO, X_HI);
        y_mov = move_axis(y_q, btnstate[3:2], step, Y_LO, Y_HI);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        if (gameover) begin
            state_d = ALIVE;
            x_d     = X_RST;
            y_d     = Y_RST;
            lives_d = L_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (hit) begin
                        lives_d = lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_d = DEAD;
                        end else begin
                            x_d     = X_RST;
                            y_d     = Y_RST;
                            cnt_d   = CNT_LD;
                            state_d = INVUL;
                        end
                    end else begin
                        x_d = x_mov;
                        y_d = y_mov;
                    end
                end
                INVUL: begin
                    x_d = x_mov;
                    y_d = y_mov;
                    if (cnt_q == '0) begin
                        state_d = ALIVE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
        invul_d = (state_d == INVUL);
        dead_d  = (state_d == DEAD);
    end

    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALIVE;
            x_q     <= X_RST;
            y_q     <= Y_RST;
            lives_q <= L_RST;
            cnt_q   <= '0;
            invul_q <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            invul_q <= invul_d;
            dead_q  <= dead_d;
        end
    end

    assign reimux = x_q;
    assign reimuy = y_q;
    assign lives  = lives_q;
    assign invul  = invul_q;
    assign dead   = dead_q;

endmodule

// File: tb/tb_player_ctrl.sv
`timescale 1ns/1ps
// tb_player_ctrl: scoreboard bench for player_ctrl; a behavioural model queues expected outputs per tick.
module tb_player_ctrl;

    localparam int XMIN = 10, XMAX = 430, YMIN = 10, YMAX = 465;
    localparam int XI = 220, YI = 360, NLIVES = 3, ITICKS = 64;

    logic       clk22 = 1'b0;
    logic       rst_n, gameover, hit, focus;
    logic [3:0] btnstate;
    logic [9:0] reimux, reimuy;
    logic       invul, dead;
    logic [2:0] lives;

    player_ctrl dut (
        .clk22(clk22), .rst_n(rst_n), .gameover(gameover), .hit(hit), .focus(focus),
        .btnstate(btnstate), .reimux(reimux), .reimuy(reimuy), .invul(invul),
        .lives(lives), .dead(dead)
    );

    always #5 clk22 = ~clk22;

    typedef struct {
        int x;
        int y;
        int lv;
        int inv;
        int dd;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int mx, my, ml, mst, mcnt;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int modelAxis(input int p, input logic [1:0] dir, input int st,
                                     input int lo, input int hi);
        int r;
        if (dir == 2'b10) r = p - st;
        else if (dir == 2'b01) r = p + st;
        else return p;
        if (r < lo) r = lo;
        if (r > hi) r = hi;
        return r;
    endfunction

    task automatic modelReset();
        mx = XI; my = YI; ml = NLIVES; mst = 0; mcnt = 0;
    endtask

    task automatic modelMove(input logic f, input logic [3:0] btn);
        int st;
        st = f ? 3 : 7;
`ifdef PLAYER_DIAG_NORM_EN
        if ((btn[1] ^ btn[0]) && (btn[3] ^ btn[2])) st = (st * 3) / 4;
`endif
        mx = modelAxis(mx, btn[1:0], st, XMIN, XMAX);
        my = modelAxis(my, btn[3:2], st, YMIN, YMAX);
    endtask

    task automatic modelStep(input logic gov, input logic h, input logic f, input logic [3:0] btn);
        if (gov) begin
            modelReset();
        end else if (mst == 0) begin
            if (h) begin
                if (ml == 1) begin
                    ml = 0; mst = 2;
                end else begin
                    ml = ml - 1; mx = XI; my = YI; mcnt = ITICKS - 1; mst = 1;
                end
            end else begin
                modelMove(f, btn);
            end
        end else if (mst == 1) begin
            modelMove(f, btn);
            if (mcnt == 0) mst = 0;
            else mcnt = mcnt - 1;
        end
    endtask

    task automatic applyStimulus(input logic gov, input logic h, input logic f, input logic [3:0] btn);
        exp_t e;
        @(negedge clk22);
        gameover = gov; hit = h; focus = f; btnstate = btn;
        modelStep(gov, h, f, btn);
        sb.push_back('{mx, my, ml, int'(mst == 1), int'(mst == 2)});
        @(posedge clk22);
        #1;
        e = sb.pop_front();
        checkOutput("x", int'(reimux), e.x);
        checkOutput("y", int'(reimuy), e.y);
        checkOutput("lives", int'(lives), e.lv);
        checkOutput("invul", int'(invul), e.inv);
        checkOutput("dead", int'(dead), e.dd);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_x"}, int'(reimux), XI);
        checkOutput({tag, "_y"}, int'(reimuy), YI);
        checkOutput({tag, "_lives"}, int'(lives), NLIVES);
        checkOutput({tag, "_invul"}, int'(invul), 0);
        checkOutput({tag, "_dead"}, int'(dead), 0);
    endtask

    initial begin
        int invCount;
        rst_n = 1'b0; gameover = 1'b0; hit = 1'b0; focus = 1'b0; btnstate = 4'b0000;
        modelReset();
        #12;
        checkResetValues("por");
        @(negedge clk22);
        rst_n = 1'b1;

        // Right held: saturates at XMAX; then up+down and left+right cancel.
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        checkOutput("x_sat", int'(reimux), XMAX);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1101);
        checkOutput("ud_cancel_y", int'(reimuy), YI);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111);

        // Asynchronous reset mid-move.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async");
        modelReset();
        btnstate = 4'b0000;
        @(negedge clk22);
        rst_n = 1'b1;

        // Walk left to 17, then focus steps 14, 11, 10, 10.
        for (int i = 0; i < 29; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
        checkOutput("focus_14", int'(reimux), 14);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
        checkOutput("focus_11", int'(reimux), 11);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
        checkOutput("focus_10", int'(reimux), 10);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
        checkOutput("floor_10", int'(reimux), 10);

        // Reach (300,200), take a hit, count invulnerable ticks while hits keep arriving.
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 22; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b1000);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'b1000);
        checkOutput("at_300", int'(reimux), 300);
        checkOutput("at_200", int'(reimuy), 200);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001);
        checkOutput("respawn_x", int'(reimux), XI);
        checkOutput("respawn_lives", int'(lives), 2);
        invCount = int'(invul);
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b0, (i < 60), 1'b0, (i % 2 == 0) ? 4'b0100 : 4'b1000);
            invCount += int'(invul);
        end
        checkOutput("invul_len", invCount, ITICKS);
        checkOutput("lives_after_invul", int'(lives), 2);

        // Remaining two hits, then death freezes everything until gameover.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 66; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
        checkOutput("lives_zero", int'(lives), 0);
        checkOutput("dead_flag", int'(dead), 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, i[0], 1'b0, 4'b1010);
        checkOutput("frozen_x", int'(reimux), XI);
        checkOutput("frozen_y", int'(reimuy), YI);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b1010);
        checkResetValues("gameover");

        // Diagonal step from spawn.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1001);
`ifdef PLAYER_DIAG_NORM_EN
        checkOutput("diag_x", int'(reimux), 225);
        checkOutput("diag_y", int'(reimuy), 355);
`else
        checkOutput("diag_x", int'(reimux), 227);
        checkOutput("diag_y", int'(reimuy), 353);
`endif

        // Random play.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 149) == 0), ($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
